// File: rtl/wave_period_meter_pkg.sv
// Shared definitions for the wave period meter and the square-wave generator.
// Holds the phase FSM encoding, the default tick divider and counter limits.
package wave_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Default divider: 12 clocks = 1 us at 12 MHz; the generator uses the same tick.
  localparam int TICK_DIV_DEF = 12;
  localparam int CNT_W_DEF    = 8;
  localparam int CNT_MAX      = (1 << CNT_W_DEF) - 1;

  // Saturation value of a w-bit phase counter.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/wave_period_meter_tick_prescaler.sv
// Free-running tick divider: counts 0..TICK_DIV-1 and flags the last count.
// A clear restarts the count so that the next tick lands TICK_DIV cycles later.
module tick_prescaler
  import wave_period_meter_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;

  // Divider counter: wrap at LAST, restart on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clear || (pcnt == LAST)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == LAST);

endmodule

// File: rtl/wave_period_meter.sv
// Measures high and low phase durations of wave_in in prescaled ticks and
// reports them once per complete period with a one-cycle valid strobe.
// Optional macro WAVE_PERIOD_METER_SYNC_EN inserts a two-flop synchronizer
// in front of the edge register (adds two cycles of latency, same counts).
//
// state | meaning
// IDLE  | after reset, waiting for the first rising edge
// HIGH  | counting ticks of the high phase into hcnt
// LOW   | counting ticks of the low phase into lcnt
module wave_period_meter
  import wave_period_meter_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wave_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] low_count,
  output logic             valid,
  output logic             sat,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(cnt_max(CNT_W));

  logic w_pre;

`ifdef WAVE_PERIOD_METER_SYNC_EN
  localparam int VLD_D = 4;
  logic [1:0] sync_q;

  // Two-flop synchronizer for an asynchronous wave source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], wave_in};
    end
  end

  assign w_pre = sync_q[1];
`else
  localparam int VLD_D = 2;
  assign w_pre = wave_in;
`endif

  logic             w_q, w_d;
  logic [VLD_D-1:0] vld;
  logic             primed;
  logic             rise, fall;
  logic             pre_edge;
  logic             tick;

  // Edge register plus a fill marker: edges only count once w_d holds a real
  // sample, so a level already present at reset release is not taken as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q <= 1'b0;
      w_d <= 1'b0;
      vld <= '0;
    end else begin
      w_q <= w_pre;
      w_d <= w_q;
      vld <= {vld[VLD_D-2:0], 1'b1};
    end
  end

  assign primed = vld[VLD_D-1];
  assign rise   = primed &  w_q & ~w_d;
  assign fall   = primed & ~w_q &  w_d;

  // The prescaler is cleared one cycle ahead of the detected edge, so it sits at
  // 0 in the edge cycle itself. The edge cycle is then tick slot 0 of the new
  // phase (count = floor(L/TICK_DIV)) and a tick can never coincide with an edge.
  assign pre_edge = w_pre ^ w_q;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(pre_edge),
    .tick (tick)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hcnt, lcnt, hcnt_nxt, lcnt_nxt;
  logic [CNT_W-1:0] hcnt_inc, lcnt_inc;
  logic             sat_i, sat_i_nxt;
  logic             report;

  assign hcnt_inc = hcnt + 1'b1;
  assign lcnt_inc = lcnt + 1'b1;

  // State and phase counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
      lcnt  <= '0;
      sat_i <= 1'b0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      lcnt  <= lcnt_nxt;
      sat_i <= sat_i_nxt;
    end
  end

  // Next state, saturating phase counters and the report request.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    lcnt_nxt  = lcnt;
    sat_i_nxt = sat_i;
    report    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          hcnt_nxt  = '0;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          lcnt_nxt  = '0;
          state_nxt = LOW;
        end else if (tick && (hcnt != CNT_LIM)) begin
          hcnt_nxt = hcnt_inc;
          if (hcnt_inc == CNT_LIM) begin
            sat_i_nxt = 1'b1;
          end
        end
      end
      LOW: begin
        if (rise) begin
          hcnt_nxt  = '0;
          state_nxt = HIGH;
          report    = 1'b1;
          sat_i_nxt = 1'b0;
        end else if (tick && (lcnt != CNT_LIM)) begin
          lcnt_nxt = lcnt_inc;
          if (lcnt_inc == CNT_LIM) begin
            sat_i_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result latch: counts and saturation flag of the period that just closed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      high_count <= '0;
      low_count  <= '0;
      sat        <= 1'b0;
    end else begin
      valid <= report;
      if (report) begin
        high_count <= hcnt;
        low_count  <= lcnt;
        sat        <= sat_i;
      end
    end
  end

  assign stuck = ((state == HIGH) && (hcnt == CNT_LIM)) ||
                 ((state == LOW)  && (lcnt == CNT_LIM));

endmodule

// File: tb/tb_wave_period_meter.sv
// Bench for wave_period_meter: two instances (CNT_W=8 and CNT_W=4, TICK_DIV=4)
// share one directed waveform and are checked every cycle against a run-length
// model of the input, plus literal expectations per scenario.
module tb_wave_period_meter;

  localparam int TD = 4;
`ifdef WAVE_PERIOD_METER_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif
  localparam int LAT = 2 + DLY;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wave_in = 1'b0;
  logic [7:0] hc_a, lc_a;
  logic       v_a, s_a, st_a;
  logic [3:0] hc_b, lc_b;
  logic       v_b, s_b, st_b;

  wave_period_meter #(.TICK_DIV(TD), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .wave_in(wave_in),
    .high_count(hc_a), .low_count(lc_a), .valid(v_a), .sat(s_a), .stuck(st_a)
  );

  wave_period_meter #(.TICK_DIV(TD), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .wave_in(wave_in),
    .high_count(hc_b), .low_count(lc_b), .valid(v_b), .sat(s_b), .stuck(st_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // ---------------- model: run lengths of the sampled input ----------------
  int maxv[2] = '{255, 15};
  int m_hc[2], m_lc[2], m_sat[2], m_valid[2], m_stuck[2];
  int p_pend[2], p_h[2], p_l[2], p_s[2];
  int phase, run, prev, have_prev, h_len, ns;
  int dl[2];

  always @(posedge clk or posedge reset) begin : model_p
    int x;
    int r_prev;
    int m_prev;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_hc[i] = 0; m_lc[i] = 0; m_sat[i] = 0; m_valid[i] = 0; m_stuck[i] = 0;
        p_pend[i] = 0; p_h[i] = 0; p_l[i] = 0; p_s[i] = 0;
      end
      phase = 0; run = 0; prev = 0; have_prev = 0; h_len = 0; ns = 0;
      dl[0] = 0; dl[1] = 0;
    end else begin
      if (ns < 1000) ns++;
      if (DLY == 0) x = int'(wave_in);
      else begin
        x = dl[1]; dl[1] = dl[0]; dl[0] = int'(wave_in);
      end
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 0;
        if (p_pend[i] != 0) begin
          m_valid[i] = 1; m_hc[i] = p_h[i]; m_lc[i] = p_l[i]; m_sat[i] = p_s[i];
          p_pend[i] = 0;
        end
      end
      r_prev = run;
      m_prev = (phase != 0) ? 1 : 0;
      if (ns > DLY) begin
        if (have_prev == 0) begin
          have_prev = 1; prev = x; run = 1;
        end else if (x != prev) begin
          if (x == 1) begin
            if (phase == 2) begin
              for (int i = 0; i < 2; i++) begin
                p_pend[i] = 1;
                p_h[i] = (h_len / TD > maxv[i]) ? maxv[i] : h_len / TD;
                p_l[i] = (run / TD > maxv[i]) ? maxv[i] : run / TD;
                p_s[i] = ((h_len / TD >= maxv[i]) || (run / TD >= maxv[i])) ? 1 : 0;
              end
            end
            phase = 1;
          end else if (phase == 1) begin
            h_len = run; phase = 2;
          end
          run = 1; prev = x;
        end else begin
          run++;
        end
      end
      for (int i = 0; i < 2; i++)
        m_stuck[i] = ((m_prev != 0) && (r_prev / TD >= maxv[i])) ? 1 : 0;
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  time qa_t[$];
  int  qa_h[$], qa_l[$], qa_s[$];
  int  qb_h[$], qb_l[$], qb_s[$];
  int  n_stuck_b = 0;

  always @(negedge clk) begin
    chk("valid_a", int'(v_a),  m_valid[0]);
    chk("stuck_a", int'(st_a), m_stuck[0]);
    chk("hcnt_a",  int'(hc_a), m_hc[0]);
    chk("lcnt_a",  int'(lc_a), m_lc[0]);
    chk("sat_a",   int'(s_a),  m_sat[0]);
    chk("valid_b", int'(v_b),  m_valid[1]);
    chk("stuck_b", int'(st_b), m_stuck[1]);
    chk("hcnt_b",  int'(hc_b), m_hc[1]);
    chk("lcnt_b",  int'(lc_b), m_lc[1]);
    chk("sat_b",   int'(s_b),  m_sat[1]);
    if (v_a) begin
      qa_t.push_back($time); qa_h.push_back(int'(hc_a));
      qa_l.push_back(int'(lc_a)); qa_s.push_back(int'(s_a));
    end
    if (v_b) begin
      qb_h.push_back(int'(hc_b)); qb_l.push_back(int'(lc_b)); qb_s.push_back(int'(s_b));
    end
    if (st_b) n_stuck_b++;
  end

  task automatic wphase(input logic v, input int n);
    wave_in = v;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    time t_rise;
    int  b, idx, lat, s0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // S1: 20 high / 12 low repeated
    b = qa_t.size();
    wphase(1'b0, 5);
    for (int p = 0; p < 4; p++) begin
      if (p == 2) begin
        t_rise = $time; idx = qa_t.size();
      end
      wphase(1'b1, 20);
      wphase(1'b0, 12);
    end
    wphase(1'b1, 20);
    wphase(1'b0, 12);
    lat = (qa_t.size() > idx) ? int'((qa_t[idx] - t_rise) / 10) : -1;
    chk("s1_latency", lat, LAT);
    chk("s1_valids", qa_t.size() - b, 4);
    chk("s1_period", (qa_t.size() >= b + 3) ? int'((qa_t[b+2] - qa_t[b+1]) / 10) : -1, 32);
    chk("s1_hc_a", int'(hc_a), 5);
    chk("s1_lc_a", int'(lc_a), 3);
    chk("s1_sat_a", int'(s_a), 0);
    chk("s1_hc_b", int'(hc_b), 5);
    chk("s1_lc_b", int'(lc_b), 3);

    // S2: reset released in the middle of a high phase
    #1 reset = 1'b1;
    wave_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    b = qa_t.size();
    wphase(1'b1, 30);
    wphase(1'b0, 12);
    chk("s2_no_early_valid", qa_t.size() - b, 0);
    wphase(1'b1, 20);
    wphase(1'b0, 12);
    wphase(1'b1, 20);
    wphase(1'b0, 12);
    chk("s2_valids", qa_t.size() - b, 1);
    chk("s2_hc_a", int'(hc_a), 5);
    chk("s2_lc_a", int'(lc_a), 3);

    // S3: 80-cycle high saturates the 4-bit counter
    b  = qa_h.size();
    idx = qb_h.size();
    s0 = n_stuck_b;
    wphase(1'b1, 80);
    wphase(1'b0, 8);
    wphase(1'b1, 20);
    wphase(1'b0, 12);
    wphase(1'b1, 4);
    wphase(1'b0, 10);
    chk("s3_hc_b_sat", (qb_h.size() > idx + 1) ? qb_h[idx+1] : -1, 15);
    chk("s3_lc_b_sat", (qb_l.size() > idx + 1) ? qb_l[idx+1] : -1, 2);
    chk("s3_sat_b",    (qb_s.size() > idx + 1) ? qb_s[idx+1] : -1, 1);
    chk("s3_hc_a_long", (qa_h.size() > b + 1) ? qa_h[b+1] : -1, 20);
    chk("s3_sat_a",     (qa_s.size() > b + 1) ? qa_s[b+1] : -1, 0);
    chk("s3_stuck_cycles", n_stuck_b - s0, 21);
    chk("s3_next_sat_b", int'(s_b), 0);
    chk("s3_next_hc_b", int'(hc_b), 5);

    // S4: constant high for 200 cycles
    idx = qb_h.size();
    wphase(1'b1, 200);
    chk("s4_stuck_b", int'(st_b), 1);
    chk("s4_stuck_a", int'(st_a), 0);
    chk("s4_valids_b", qb_h.size() - idx, 1);
    chk("s4_hold_hc_b", int'(hc_b), 1);
    chk("s4_hold_lc_b", int'(lc_b), 2);

    // S5: reset during a low phase, then fresh periods incl. a sub-tick phase
    wphase(1'b0, 6);
    #1 reset = 1'b1;
    #1;
    chk("s5_async_hc_a", int'(hc_a), 0);
    chk("s5_async_lc_b", int'(lc_b), 0);
    chk("s5_async_valid", int'(v_a), 0);
    chk("s5_async_stuck", int'(st_b), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    b = qa_t.size();
    wphase(1'b0, 10);
    wphase(1'b1, 20);
    wphase(1'b0, 12);
    wphase(1'b1, 20);
    wphase(1'b0, 12);
    wphase(1'b1, 3);
    wphase(1'b0, 12);
    wphase(1'b1, 2);
    wphase(1'b0, 5);
    chk("s5_valids", qa_t.size() - b, 3);
    chk("s5_first_hc", (qa_h.size() > b) ? qa_h[b] : -1, 5);
    chk("s5_short_hc", int'(hc_a), 0);
    chk("s5_short_lc", int'(lc_a), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
